// File: rtl/seg_scan_if.sv
// Scanned seven-segment bus plus the decoded readback from seg_scan_decoder.
// master drives seg/an (display side); slave is the decoder.
interface seg_scan_if #(
  parameter int unsigned NDIG = 8
);
  logic [7:0]        seg;
  logic [NDIG-1:0]   an;
  logic [4*NDIG-1:0] value;
  logic [NDIG-1:0]   dp_out;
  logic [NDIG-1:0]   digit_valid;
  logic              frame_done;
  logic              err;
  logic [2:0]        err_digit;

  modport master (
    output seg, an,
    input  value, dp_out, digit_valid, frame_done, err, err_digit
  );

  modport slave (
    input  seg, an,
    output value, dp_out, digit_valid, frame_done, err, err_digit
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// Decodes a scanned active-low seven-segment bus back into hex nibbles once
// each digit's dwell has been stable for STABLE_CYC samples.
module seg_scan_decoder #(
  parameter int unsigned NDIG       = 8,
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  seg_scan_if.slave   bus
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = 3;
  localparam logic [CNT_W-1:0] STABLE_N = CNT_W'(STABLE_CYC);

  typedef enum logic [1:0] {IDLE, COUNT, HELD} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [7:0]        s_seg, p_seg;
  logic [NDIG-1:0]   s_an, p_an;
  logic [NDIG-1:0]   cap_mask;
  logic              ghost_armed;

  logic [4*NDIG-1:0] value_q;
  logic [NDIG-1:0]   dp_q;
  logic [NDIG-1:0]   valid_q;
  logic              frame_done_q;
  logic              err_q;
  logic [IDX_W-1:0]  err_digit_q;

  logic [3:0]        low_cnt;
  logic [IDX_W-1:0]  dig_idx;
  logic              one_low, ghost, changed;
  logic [CNT_W-1:0]  cnt_inc;
  logic [4:0]        glyph;
  logic              blank;
  logic [NDIG-1:0]   mask_set;

  // Lit pattern a..g MSB-first -> {legal, hex code}
  function automatic logic [4:0] decode_glyph(input logic [6:0] lit);
    case (lit)
      7'b1111110: decode_glyph = {1'b1, 4'h0};
      7'b0110000: decode_glyph = {1'b1, 4'h1};
      7'b1101101: decode_glyph = {1'b1, 4'h2};
      7'b1111001: decode_glyph = {1'b1, 4'h3};
      7'b0110011: decode_glyph = {1'b1, 4'h4};
      7'b1011011: decode_glyph = {1'b1, 4'h5};
      7'b1011111: decode_glyph = {1'b1, 4'h6};
      7'b1110000: decode_glyph = {1'b1, 4'h7};
      7'b1111111: decode_glyph = {1'b1, 4'h8};
      7'b1110011: decode_glyph = {1'b1, 4'h9};
      7'b1110111: decode_glyph = {1'b1, 4'hA};
      7'b0011111: decode_glyph = {1'b1, 4'hB};
      7'b0001101: decode_glyph = {1'b1, 4'hC};
      7'b0111101: decode_glyph = {1'b1, 4'hD};
      7'b1101111: decode_glyph = {1'b1, 4'hE};
      7'b1000111: decode_glyph = {1'b1, 4'hF};
      default:    decode_glyph = 5'b0;
    endcase
  endfunction

  // Anode classification: count of low enables and index of the low one
  always_comb begin
    low_cnt = '0;
    dig_idx = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (!s_an[i]) begin
        low_cnt = low_cnt + 4'd1;
        dig_idx = IDX_W'(i);
      end
    end
  end

  assign one_low  = (low_cnt == 4'd1);
  assign ghost    = (low_cnt >= 4'd2);
  assign changed  = (s_seg != p_seg) || (s_an != p_an);
  assign cnt_inc  = CNT_W'(cnt + CNT_W'(1));
  assign glyph    = decode_glyph(~s_seg[7:1]);
  assign blank    = (s_seg[7:1] == 7'h7F);
  assign mask_set = cap_mask | (NDIG'(1) << dig_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      s_seg        <= '1;
      p_seg        <= '1;
      s_an         <= '1;
      p_an         <= '1;
      cap_mask     <= '0;
      ghost_armed  <= 1'b0;
      value_q      <= '0;
      dp_q         <= '0;
      valid_q      <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      err_digit_q  <= '0;
    end else begin
      s_seg        <= bus.seg;
      s_an         <= bus.an;
      p_seg        <= s_seg;
      p_an         <= s_an;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      // A ghost dwell is armed once two consecutive samples agree
      ghost_armed  <= ghost && !changed;

      if (changed && ghost_armed) begin
        err_q       <= 1'b1;
        err_digit_q <= '0;
        state       <= IDLE;
        cnt         <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (one_low) begin
              state <= COUNT;
              cnt   <= CNT_W'(1);
            end else begin
              cnt <= '0;
            end
          end
          COUNT: begin
            if (!one_low) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (changed) begin
              cnt <= CNT_W'(1);
            end else if (cnt_inc == STABLE_N) begin
              cnt                       <= cnt_inc;
              state                     <= HELD;
              dp_q[dig_idx]             <= ~s_seg[0];
              valid_q[dig_idx]          <= glyph[4];
              if (glyph[4]) value_q[{dig_idx, 2'b00} +: 4] <= glyph[3:0];
              if (!glyph[4] && !blank) begin
                err_q       <= 1'b1;
                err_digit_q <= dig_idx;
              end
              if (&mask_set) begin
                frame_done_q <= 1'b1;
                cap_mask     <= '0;
              end else begin
                cap_mask <= mask_set;
              end
            end else begin
              cnt <= cnt_inc;
            end
          end
          HELD: begin
            if (changed) begin
              state <= one_low ? COUNT : IDLE;
              cnt   <= one_low ? CNT_W'(1) : '0;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.value       = value_q;
  assign bus.dp_out      = dp_q;
  assign bus.digit_valid = valid_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.err         = err_q;
  assign bus.err_digit   = err_digit_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: reset, decode, stability filter,
// frame assembly, glyph/ghost errors and blank/hold behaviour.
module tb_seg_scan_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   err_cnt = 0;
  int   fd_cnt = 0;
  logic [2:0] last_err_digit = '0;
  logic [7:0] fd_an = '0;
  int   e0, f0;
  logic [6:0] lit_tab [8];

  seg_scan_if #(.NDIG(8)) bus ();

  seg_scan_decoder #(.NDIG(8), .STABLE_CYC(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Pulse monitor; outputs change on posedge, sampled on negedge
  always @(negedge clk) begin
    if (bus.err) begin
      err_cnt <= err_cnt + 1;
      last_err_digit <= bus.err_digit;
    end
    if (bus.frame_done) begin
      fd_cnt <= fd_cnt + 1;
      fd_an  <= bus.an;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] an, input logic [7:0] seg);
    bus.an  = an;
    bus.seg = seg;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    lit_tab[0] = 7'b1111110; lit_tab[1] = 7'b0110000;
    lit_tab[2] = 7'b1101101; lit_tab[3] = 7'b1111001;
    lit_tab[4] = 7'b0110011; lit_tab[5] = 7'b1011011;
    lit_tab[6] = 7'b1011111; lit_tab[7] = 7'b1110000;
    drive(8'hFF, 8'hFF);

    // Power-on reset held for 3 cycles
    wait_neg(3);
    chk("rst_value", bus.value, 32'h0);
    chk("rst_dv",    32'(bus.digit_valid), 32'h0);
    chk("rst_pulse", {29'h0, bus.err, bus.frame_done, 1'b0} | 32'(bus.err_digit), 32'h0);
    rst = 1'b0;
    wait_neg(2);

    // Decode '3' on digit 0 with exact latency
    drive(8'hFE, ~8'hF2);
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1 chk("t2_early", 32'(bus.digit_valid[0]), 32'h0);
    @(posedge clk);
    #1 chk("t2_dv0", 32'(bus.digit_valid[0]), 32'h1);
    chk("t2_val", 32'(bus.value[3:0]), 32'h3);
    chk("t2_dp0", 32'(bus.dp_out[0]), 32'h0);
    @(negedge clk);
    drive(8'hFE, ~8'hF3);
    wait_neg(6);
    chk("t2_dp1", 32'(bus.dp_out[0]), 32'h1);
    chk("t2_val_keep", 32'(bus.value[3:0]), 32'h3);
    chk("t2_noerr", 32'(err_cnt), 32'h0);

    // Alternating glyphs every 3 cycles never settle
    for (int r = 0; r < 4; r++) begin
      drive(8'hFD, ~8'h60);
      wait_neg(3);
      drive(8'hFD, ~8'hDA);
      wait_neg(3);
    end
    chk("t3_nocap_val", 32'(bus.value[7:4]), 32'h0);
    chk("t3_nocap_dv",  32'(bus.digit_valid[1]), 32'h0);
    wait_neg(6);
    chk("t3_val", 32'(bus.value[7:4]), 32'h2);
    chk("t3_dv",  32'(bus.digit_valid[1]), 32'h1);

    // Full frame scan 0..7
    f0 = fd_cnt;
    for (int d = 0; d < 8; d++) begin
      drive(~(8'h01 << d), ~{lit_tab[d], 1'b0});
      wait_neg(6);
    end
    chk("t4_value", bus.value, 32'h76543210);
    chk("t4_dv",    32'(bus.digit_valid), 32'hFF);
    chk("t4_dp",    32'(bus.dp_out), 32'h0);
    chk("t4_fd_cnt", 32'(fd_cnt - f0), 32'h1);
    chk("t4_fd_an",  32'(fd_an), 32'h7F);

    // Illegal glyph on digit 2, then a ghost dwell
    e0 = err_cnt;
    drive(8'hFB, ~8'h02);
    wait_neg(6);
    chk("t5_gerr_cnt", 32'(err_cnt - e0), 32'h1);
    chk("t5_gerr_dig", 32'(last_err_digit), 32'h2);
    chk("t5_dv2",      32'(bus.digit_valid[2]), 32'h0);
    chk("t5_val_keep", bus.value, 32'h76543210);
    e0 = err_cnt;
    drive(8'hFC, ~8'h02);
    wait_neg(3);
    chk("t5_ghost_quiet", 32'(err_cnt - e0), 32'h0);
    drive(8'hFF, ~8'h02);
    wait_neg(6);
    chk("t5_ghost_cnt", 32'(err_cnt - e0), 32'h1);
    chk("t5_ghost_dig", 32'(bus.err_digit), 32'h0);

    // Blank digit 4, then idle bus
    e0 = err_cnt;
    f0 = fd_cnt;
    drive(8'hEF, 8'hFF);
    wait_neg(6);
    chk("t6_dv4",    32'(bus.digit_valid[4]), 32'h0);
    chk("t6_val4",   32'(bus.value[19:16]), 32'h4);
    chk("t6_noerr",  32'(err_cnt - e0), 32'h0);
    drive(8'hFF, 8'hFF);
    wait_neg(20);
    chk("t6_hold_val", bus.value, 32'h76543210);
    chk("t6_hold_dv",  32'(bus.digit_valid), 32'hEB);
    chk("t6_hold_dp",  32'(bus.dp_out), 32'h0);
    chk("t6_hold_pulses", 32'(err_cnt - e0) + 32'(fd_cnt - f0), 32'h0);

    // Asynchronous reset mid-cycle clears before the next edge
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t1_async_val", bus.value, 32'h0);
    chk("t1_async_dv",  32'(bus.digit_valid), 32'h0);
    chk("t1_async_dp",  32'(bus.dp_out), 32'h0);
    wait_neg(3);
    chk("t1_hold_val", bus.value, 32'h0);
    chk("t1_hold_misc", {24'h0, bus.err, bus.frame_done, 3'h0, bus.err_digit}, 32'h0);
    rst = 1'b0;
    wait_neg(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
